// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word requests,
// buffers responses with their PCs in a prefetch FIFO and hands them to the core.
module fetch_unit #(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          Address   = 8,
  parameter int unsigned          FifoDepth = 4,
  parameter logic [DataWidth-1:0] ResetPc   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [Address-1:0]   imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [DataWidth-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [DataWidth-1:0] redirect_pc,
  output logic                 instr_valid,
  output logic [DataWidth-1:0] instr,
  output logic [DataWidth-1:0] instr_pc,
  input  logic                 instr_ready
);

  localparam int unsigned     PtrW   = $clog2(FifoDepth);
  localparam int unsigned     CntW   = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FifoDepth);

  logic [DataWidth-1:0] fpc_q, fpc_d, rpc_q, rpc_d;
  logic [CntW-1:0]      outst_q, outst_d, disc_q, disc_d, count_q, count_d;
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DataWidth-1:0] fifo_instr_q [FifoDepth];
  logic [DataWidth-1:0] fifo_pc_q    [FifoDepth];

  logic                 grant, resp, push, pop;
  logic [CntW:0]        credit_used, disc_sum;
  logic [DataWidth-1:0] redir_pc;
  logic                 unused;

  assign unused = ^redirect_pc[1:0];

  // Outstanding requests plus buffered words never exceed the FIFO depth.
  assign credit_used = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req    = !rst && !redirect_valid && (credit_used < {1'b0, DepthC});
  assign imem_addr   = rst ? ResetPc[Address+1:2] : fpc_q[Address+1:2];

  assign instr_valid = !rst && !redirect_valid && (count_q != '0);
  assign instr       = instr_valid ? fifo_instr_q[rptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rptr_q]    : '0;

  assign grant    = imem_req && imem_gnt;
  assign resp     = imem_rvalid && (outst_q != '0);
  assign pop      = instr_valid && instr_ready;
  assign push     = !rst && resp && !redirect_valid && (disc_q == '0);
  assign redir_pc = {redirect_pc[DataWidth-1:2], 2'b00};
  assign disc_sum = {1'b0, disc_q} + {1'b0, outst_q} - {{CntW{1'b0}}, resp};

  always_comb begin
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    outst_d = outst_q;
    disc_d  = disc_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (redirect_valid) begin
      // Every still-pending response belongs to the old stream and must be dropped.
      fpc_d   = redir_pc;
      rpc_d   = redir_pc;
      outst_d = outst_q - CntW'(resp);
      disc_d  = (disc_sum > {1'b0, DepthC}) ? DepthC : disc_sum[CntW-1:0];
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (grant) begin
        fpc_d = fpc_q + DataWidth'(4);
      end
      outst_d = outst_q + CntW'(grant) - CntW'(resp);
      if (resp && (disc_q != '0)) begin
        disc_d = disc_q - CntW'(1);
      end
      if (push) begin
        rpc_d  = rpc_q + DataWidth'(4);
        wptr_d = wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q   <= ResetPc;
      rpc_q   <= ResetPc;
      outst_q <= '0;
      disc_q  <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wptr_q] <= imem_rdata;
      fifo_pc_q[wptr_q]    <= rpc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && (outst_q == '0)))
        else $error("fetch_unit: imem_rvalid with no outstanding request");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, an
// in-order memory responder with programmable latency, and directed scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid, redirect_valid;
  logic        instr_valid, instr_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata, redirect_pc, instr, instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.DataWidth(32), .Address(8), .FifoDepth(4), .ResetPc(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: plain counters and a queue of {instr, pc}.
  logic [31:0] m_fpc = '0, m_rpc = '0;
  int          m_out = 0, m_disc = 0;
  logic [63:0] m_q[$];

  typedef struct { logic [31:0] pc; int due; } req_t;
  req_t        rq[$];
  int          cyc = 0, lat = 1, last_due = 0;
  logic [31:0] dpc[$];

  bit          m_grant, m_rv, m_pop;
  int          m_d, m_due;
  logic [31:0] m_rp;

  function automatic logic [31:0] mem_word(logic [7:0] a);
    return 32'hC0DE0000 | {24'h0, a};
  endfunction

  function automatic bit e_req();
    return !rst && !redirect_valid && (m_out + m_q.size() < 4);
  endfunction
  function automatic bit e_valid();
    return !rst && !redirect_valid && (m_q.size() != 0);
  endfunction
  function automatic logic [7:0] e_addr();
    return rst ? 8'h00 : m_fpc[9:2];
  endfunction
  function automatic logic [31:0] e_instr();
    return e_valid() ? m_q[0][63:32] : 32'h0;
  endfunction
  function automatic logic [31:0] e_pc();
    return e_valid() ? m_q[0][31:0] : 32'h0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    chk("req",   {31'h0, imem_req},    {31'h0, e_req()});
    chk("addr",  {24'h0, imem_addr},   {24'h0, e_addr()});
    chk("valid", {31'h0, instr_valid}, {31'h0, e_valid()});
    chk("instr", instr,                e_instr());
    chk("pc",    instr_pc,             e_pc());
    if (instr_valid && instr_ready) dpc.push_back(instr_pc);
  end

  // Model update at the edge, then the memory responder drives the new cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_fpc = '0; m_rpc = '0; m_out = 0; m_disc = 0;
      m_q.delete(); rq.delete(); last_due = cyc;
    end else begin
      m_grant = e_req() && imem_gnt;
      m_rv    = imem_rvalid;
      m_pop   = e_valid() && instr_ready;
      if (redirect_valid) begin
        m_rp   = {redirect_pc[31:2], 2'b00};
        m_q.delete();
        m_fpc  = m_rp;
        m_rpc  = m_rp;
        m_d    = m_disc + m_out - int'(m_rv);
        m_disc = (m_d > 4) ? 4 : m_d;
        m_out  = m_out - int'(m_rv);
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_grant) begin
          m_due = cyc + lat;
          if (m_due <= last_due) m_due = last_due + 1;
          last_due = m_due;
          rq.push_back('{pc: m_fpc, due: m_due});
          m_fpc = m_fpc + 32'd4;
          m_out++;
        end
        if (m_rv) begin
          m_out--;
          if (m_disc > 0) m_disc--;
          else begin
            m_q.push_back({imem_rdata, m_rpc});
            m_rpc = m_rpc + 32'd4;
          end
        end
      end
    end
    cyc++;
    #1;
    if (rq.size() != 0 && rq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(rq[0].pc[9:2]);
      void'(rq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_dpc(string name, int idx, logic [31:0] exp);
    chk(name, (dpc.size() > idx) ? dpc[idx] : 32'hDEADDEAD, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : drive
    rst = 1'b1; imem_gnt = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset then streaming with gnt=1, k=1, ready=1
    tick(1); #1;
    chk("rst_req",   {31'h0, imem_req},    32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr,                32'h0);
    chk("rst_pc",    instr_pc,             32'h0);
    chk("rst_addr",  {24'h0, imem_addr},   32'h0);
    tick(1);
    rst = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
    #1 chk("s0_valid", {31'h0, instr_valid}, 32'h0);
    chk("s0_req", {31'h0, imem_req}, 32'h1);
    tick(1); #1 chk("s1_valid", {31'h0, instr_valid}, 32'h0);
    tick(1); #1 chk("s2_valid", {31'h0, instr_valid}, 32'h1);
    chk("s2_pc", instr_pc, 32'h0);
    chk("s2_instr", instr, 32'hC0DE0000);
    tick(1); #1 chk("s3_pc", instr_pc, 32'h4);
    chk("s3_instr", instr, 32'hC0DE0001);
    tick(1); #1 chk("s4_pc", instr_pc, 32'h8);
    tick(8);

    // Backpressure: FIFO fills to 4, requests stop, then drains in order
    rst = 1'b1; instr_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(6); #1;
    chk("bp_req",   {31'h0, imem_req},    32'h0);
    chk("bp_valid", {31'h0, instr_valid}, 32'h1);
    chk("bp_pc",    instr_pc,             32'h0);
    dpc.delete();
    instr_ready = 1'b1;
    tick(4);
    chk_dpc("bp_d0", 0, 32'h0);
    chk_dpc("bp_d1", 1, 32'h4);
    chk_dpc("bp_d2", 2, 32'h8);
    chk_dpc("bp_d3", 3, 32'hC);
    tick(4);

    // Redirect with two outstanding requests, k=3
    rst = 1'b1;
    tick(2);
    rst = 1'b0; lat = 3;
    tick(2);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1 chk("rd_req", {31'h0, imem_req}, 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    dpc.delete();
    #1 chk("rd_addr", {24'h0, imem_addr}, 32'h10);
    chk("rd_req1", {31'h0, imem_req}, 32'h1);
    tick(4); #1;
    chk("rd_valid", {31'h0, instr_valid}, 32'h1);
    chk("rd_pc",    instr_pc,             32'h40);
    chk("rd_instr", instr,                32'hC0DE0010);
    tick(1);
    chk_dpc("rd_first", 0, 32'h40);
    tick(6);

    // Redirect coinciding with a response and a pop
    rst = 1'b1; lat = 1;
    tick(2);
    rst = 1'b0;
    dpc.delete();
    tick(5);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    #1 chk("sim_valid_r", {31'h0, instr_valid}, 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    #1 chk("sim_valid_r1", {31'h0, instr_valid}, 32'h0);
    tick(1); #1 chk("sim_valid_r2", {31'h0, instr_valid}, 32'h0);
    tick(1); #1 chk("sim_pc_r3", instr_pc, 32'h80);
    tick(1);
    chk("sim_count", dpc.size(), 32'd4);
    chk_dpc("sim_d0", 0, 32'h0);
    chk_dpc("sim_d1", 1, 32'h4);
    chk_dpc("sim_d2", 2, 32'h8);
    chk_dpc("sim_d3", 3, 32'h80);

    // Grant stall: request and address held for 5 cycles
    rst = 1'b1; imem_gnt = 1'b0;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("st_req", {31'h0, imem_req}, 32'h1);
      chk("st_addr", {24'h0, imem_addr}, 32'h0);
      tick(1);
    end
    imem_gnt = 1'b1;
    #1 chk("st_addr5", {24'h0, imem_addr}, 32'h0);
    tick(1); #1 chk("st_addr6", {24'h0, imem_addr}, 32'h1);
    tick(4);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    #1 chk("mis_req", {31'h0, imem_req}, 32'h0);
    tick(1);
    redirect_valid = 1'b0;
    #1 chk("mis_addr", {24'h0, imem_addr}, 32'h10);
    tick(2); #1 chk("mis_pc", instr_pc, 32'h40);
    chk("mis_instr", instr, 32'hC0DE0010);
    tick(3);

    // PC wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFF8;
    tick(1);
    redirect_valid = 1'b0;
    #1 chk("wr_addr", {24'h0, imem_addr}, 32'hFE);
    tick(2); #1 chk("wr_pc0", instr_pc, 32'hFFFFFFF8);
    tick(1); #1 chk("wr_pc1", instr_pc, 32'hFFFFFFFC);
    tick(1); #1 chk("wr_pc2", instr_pc, 32'h0);
    chk("wr_instr2", instr, 32'hC0DE0000);
    tick(2);

    // Mixed traffic against the model
    for (int i = 0; i < 400; i++) begin
      imem_gnt       = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    rst = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1; imem_gnt = 1'b1;
    tick(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
